mii_frame_gen: RTL and testbench

//  Stimulus source upstream of the 64-bit MII frame checker. Emits framed traffic on an 8-lane

---
 rtl/mii_pkg.sv | 36 +++
 rtl/mii_payload_pattern.sv | 60 ++++++
 rtl/mii_frame_gen.sv | 205 ++++++++++++++++++++
 tb/tb_mii_frame_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mii_pkg.sv
// Shared constants, state/pattern enums and the LFSR step for the MII frame generator.
package mii_pkg;

    localparam int unsigned LANES        = 8;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned BUS_W        = LANES * BYTE_W;
    localparam int unsigned FC_W         = 16;
    localparam int          START_PAY    = int'(LANES) - 1;

    localparam logic [7:0]  IDLE_CHAR    = 8'h07;
    localparam logic [7:0]  START_CHAR   = 8'hFB;
    localparam logic [7:0]  TERM_CHAR    = 8'hFD;
    localparam logic [7:0]  LFSR_SEED    = 8'hFF;
    localparam logic [7:0]  CONST_BYTE   = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_TERM  = 3'd3,
        ST_IPG   = 3'd4
    } gen_state_t;

    typedef enum logic [1:0] {
        PAT_INCR  = 2'd0,
        PAT_LFSR  = 2'd1,
        PAT_CONST = 2'd2,
        PAT_RSVD  = 2'd3
    } pattern_sel_t;

    // Fibonacci x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/mii_payload_pattern.sv
// Payload byte source: presents the next 8 payload bytes and advances by 7 (START) or 8 (DATA).
module mii_payload_pattern
    import mii_pkg::*;
(
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_adv,
    input  logic [1:0]       i_sel,
    output logic [BUS_W-1:0] o_bytes_c
);

    logic [7:0] r_cnt;
    logic [7:0] r_lfsr;
    logic [7:0] w_cnt7;
    logic [7:0] w_lfsr7;
    logic [7:0] w_cnt8;
    logic [7:0] w_lfsr8;

    // Unroll 8 byte steps from the current (or freshly seeded) state.
    always_comb begin
        logic [7:0] v_cnt;
        logic [7:0] v_lfsr;
        o_bytes_c = '0;
        w_cnt7    = '0;
        w_lfsr7   = '0;
        v_cnt     = i_clear ? 8'h00 : r_cnt;
        v_lfsr    = i_clear ? LFSR_SEED : r_lfsr;
        for (int i = 0; i < int'(LANES); i++) begin
            case (pattern_sel_t'(i_sel))
                PAT_LFSR:  o_bytes_c[BYTE_W*i +: BYTE_W] = v_lfsr;
                PAT_CONST: o_bytes_c[BYTE_W*i +: BYTE_W] = CONST_BYTE;
                default:   o_bytes_c[BYTE_W*i +: BYTE_W] = v_cnt;
            endcase
            v_cnt  = v_cnt + 8'd1;
            v_lfsr = lfsr8_step(v_lfsr);
            if (i == START_PAY - 1) begin
                w_cnt7  = v_cnt;
                w_lfsr7 = v_lfsr;
            end
        end
        w_cnt8  = v_cnt;
        w_lfsr8 = v_lfsr;
    end

    // Generator state: restart at byte 0 on START, skip past consumed bytes otherwise.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (i_clear) begin
            r_cnt  <= w_cnt7;
            r_lfsr <= w_lfsr7;
        end else if (i_adv) begin
            r_cnt  <= w_cnt8;
            r_lfsr <= w_lfsr8;
        end
    end

endmodule

// File: rtl/mii_frame_gen.sv
// Framed MII traffic source: START, payload, TERM and an aligned inter-packet gap of idles.
module mii_frame_gen
    import mii_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BUS_W,
    parameter int unsigned CTRL_WIDTH = LANES,
    parameter logic [7:0]  IDLE_CODE  = IDLE_CHAR,
    parameter logic [7:0]  START_CODE = START_CHAR,
    parameter logic [7:0]  TERM_CODE  = TERM_CHAR,
    parameter int unsigned LEN_W      = 11,
    parameter int unsigned IPG_W      = 8
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [LEN_W-1:0]      i_payload_len,
    input  logic [IPG_W-1:0]      i_ipg_len,
    input  logic [1:0]            i_pattern_sel,
    input  logic [FC_W-1:0]       i_frame_count,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic [FC_W-1:0]       o_frames_sent
);

    localparam int unsigned       NEED_W      = IPG_W + 1;
    localparam logic [LEN_W-1:0]  START_BYTES = LEN_W'(LANES - 1);
    localparam logic [LEN_W-1:0]  WORD_BYTES  = LEN_W'(LANES);

    gen_state_t            r_state;
    gen_state_t            w_state_nx;
    gen_state_t            w_end_state;
    logic [LEN_W-1:0]      r_rem;
    logic [LEN_W-1:0]      w_rem_nx;
    logic [LEN_W-1:0]      w_len;
    logic [IPG_W-1:0]      r_ipg;
    logic [IPG_W-1:0]      r_ipg_cnt;
    logic [IPG_W-1:0]      w_ipg_cnt_nx;
    logic [IPG_W-1:0]      w_idle_sent;
    logic [IPG_W-1:0]      w_k;
    logic [NEED_W-1:0]     w_need;
    logic [2:0]            w_term_r;
    logic [1:0]            r_pat;
    logic [1:0]            w_pat_sel;
    logic [FC_W-1:0]       r_fc;
    logic [FC_W-1:0]       r_sess;
    logic [FC_W-1:0]       r_frames_sent;
    logic                  r_hold;
    logic                  w_hold_set;
    logic                  w_exhausted;
    logic                  w_pat_clear;
    logic                  w_pat_adv;
    logic [DATA_WIDTH-1:0] w_pat_bytes;
    logic [DATA_WIDTH-1:0] w_data_nx;
    logic [CTRL_WIDTH-1:0] w_ctrl_nx;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [CTRL_WIDTH-1:0] r_tx_ctrl;
    logic                  r_busy;
    logic                  r_frame_done;

    assign w_len       = (i_payload_len < START_BYTES) ? START_BYTES : i_payload_len;
    assign w_term_r    = r_rem[2:0];
    assign w_idle_sent = IPG_W'(3'd7 - w_term_r);
    assign w_exhausted = (r_fc != '0) && (r_sess >= r_fc);
    assign w_end_state = (!i_enable || w_exhausted) ? ST_IDLE : ST_START;
    assign w_pat_clear = (w_state_nx == ST_START);
    assign w_pat_adv   = (w_state_nx == ST_DATA);
    assign w_pat_sel   = w_pat_clear ? i_pattern_sel : r_pat;

    // Full idle words still owed after the idles that pad the TERM word.
    always_comb begin
        w_need = '0;
        if (r_ipg > w_idle_sent) begin
            w_need = {1'b0, r_ipg - w_idle_sent} + NEED_W'(LANES - 1);
        end
        w_k = IPG_W'(w_need >> 3);
    end

    mii_payload_pattern u_pattern (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_pat_clear),
        .i_adv     (w_pat_adv),
        .i_sel     (w_pat_sel),
        .o_bytes_c (w_pat_bytes)
    );

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nx;
    end

    // Next state plus remaining-byte and IPG word bookkeeping.
    always_comb begin
        w_state_nx   = r_state;
        w_rem_nx     = r_rem;
        w_ipg_cnt_nx = r_ipg_cnt;
        w_hold_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && !r_hold) w_state_nx = ST_START;
            end
            ST_START, ST_DATA: begin
                if (r_rem >= WORD_BYTES) begin
                    w_state_nx = ST_DATA;
                    w_rem_nx   = r_rem - WORD_BYTES;
                end else begin
                    w_state_nx   = ST_TERM;
                    w_ipg_cnt_nx = w_k;
                end
            end
            ST_TERM: begin
                if (r_ipg_cnt == '0) begin
                    w_state_nx = w_end_state;
                    w_hold_set = w_exhausted;
                end else begin
                    w_state_nx = ST_IPG;
                end
            end
            ST_IPG: begin
                if (r_ipg_cnt <= IPG_W'(1)) begin
                    w_state_nx = w_end_state;
                    w_hold_set = w_exhausted;
                end else begin
                    w_ipg_cnt_nx = r_ipg_cnt - IPG_W'(1);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (w_state_nx == ST_START) w_rem_nx = w_len - START_BYTES;
    end

    // Bus word for the state being entered.
    always_comb begin
        w_data_nx = {CTRL_WIDTH{IDLE_CODE}};
        w_ctrl_nx = '1;
        case (w_state_nx)
            ST_START: begin
                w_data_nx = {w_pat_bytes[DATA_WIDTH-9:0], START_CODE};
                w_ctrl_nx = CTRL_WIDTH'(1);
            end
            ST_DATA: begin
                w_data_nx = w_pat_bytes;
                w_ctrl_nx = '0;
            end
            ST_TERM: begin
                for (int i = 0; i < int'(CTRL_WIDTH); i++) begin
                    if (3'(i) < w_term_r) begin
                        w_data_nx[8*i +: 8] = w_pat_bytes[8*i +: 8];
                        w_ctrl_nx[i]        = 1'b0;
                    end else if (3'(i) == w_term_r) begin
                        w_data_nx[8*i +: 8] = TERM_CODE;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs, latched config and frame counters.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem         <= '0;
            r_ipg         <= '0;
            r_ipg_cnt     <= '0;
            r_pat         <= '0;
            r_fc          <= '0;
            r_sess        <= '0;
            r_frames_sent <= '0;
            r_hold        <= 1'b0;
            r_tx_data     <= {CTRL_WIDTH{IDLE_CODE}};
            r_tx_ctrl     <= '1;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_rem        <= w_rem_nx;
            r_ipg_cnt    <= w_ipg_cnt_nx;
            r_hold       <= i_enable & (r_hold | w_hold_set);
            r_tx_data    <= w_data_nx;
            r_tx_ctrl    <= w_ctrl_nx;
            r_busy       <= (w_state_nx != ST_IDLE);
            r_frame_done <= (w_state_nx == ST_TERM);
            if (w_state_nx == ST_START) begin
                r_ipg <= i_ipg_len;
                r_pat <= i_pattern_sel;
                r_fc  <= i_frame_count;
            end
            if (w_state_nx == ST_TERM) begin
                r_sess        <= r_sess + FC_W'(1);
                r_frames_sent <= r_frames_sent + FC_W'(1);
            end else if (r_state == ST_IDLE) begin
                r_sess <= '0;
            end
        end
    end

    assign o_tx_data     = r_tx_data;
    assign o_tx_ctrl     = r_tx_ctrl;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;
    assign o_frames_sent = r_frames_sent;

endmodule

// File: tb/tb_mii_frame_gen.sv
// Self-checking bench for mii_frame_gen against a byte-stream model of the framing rules.
module tb_mii_frame_gen;

    localparam logic [63:0] IDLE_W = {8{8'h07}};

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic        done;
    } word_t;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic [10:0] i_payload_len;
    logic [7:0]  i_ipg_len;
    logic [1:0]  i_pattern_sel;
    logic [15:0] i_frame_count;
    logic [63:0] o_tx_data;
    logic [7:0]  o_tx_ctrl;
    logic        o_busy;
    logic        o_frame_done;
    logic [15:0] o_frames_sent;

    int    total = 0;
    int    bad   = 0;
    int    exp_sent = 0;
    string step = "init";
    word_t exp_q[$];
    int    fstart_q[$];

    mii_frame_gen dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .i_payload_len (i_payload_len),
        .i_ipg_len     (i_ipg_len),
        .i_pattern_sel (i_pattern_sel),
        .i_frame_count (i_frame_count),
        .o_tx_data     (o_tx_data),
        .o_tx_ctrl     (o_tx_ctrl),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_frames_sent (o_frames_sent)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, step=%s", step);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s: observed=%h expected=%h", step, tag, obs, exp);
        end
    endtask

    // Polynomial x^8+x^6+x^5+x^4+1: feedback is the parity of tap mask 0xB8.
    function automatic int lfsr_next(input int s);
        int fb;
        fb = $countones(s & 'hB8) & 1;
        return ((s << 1) | fb) & 'hFF;
    endfunction

    // Expected words: each frame is FB, payload, FD, then the fewest idles >= ipg that realign to 8.
    task automatic build(input int len, input int ipg, input int pat, input int nfr);
        logic [9:0] bq[$];
        logic [7:0] b;
        logic [9:0] e;
        int         L;
        int         s;
        int         idles;
        word_t      w;
        exp_q.delete();
        fstart_q.delete();
        for (int f = 0; f < nfr; f++) begin
            fstart_q.push_back(bq.size() / 8);
            bq.push_back({2'b01, 8'hFB});
            L = (len < 7) ? 7 : len;
            s = 'hFF;
            for (int n = 0; n < L; n++) begin
                if (pat == 1)      b = 8'(s);
                else if (pat == 2) b = 8'h55;
                else               b = 8'(n);
                bq.push_back({2'b00, b});
                s = lfsr_next(s);
            end
            bq.push_back({2'b11, 8'hFD});
            idles = 0;
            while (idles < ipg || (bq.size() % 8) != 0) begin
                bq.push_back({2'b01, 8'h07});
                idles++;
            end
        end
        for (int wi = 0; wi < bq.size() / 8; wi++) begin
            w = '0;
            for (int j = 0; j < 8; j++) begin
                e = bq[wi*8 + j];
                w.d[8*j +: 8] = e[7:0];
                w.c[j]        = e[8];
                w.done        = w.done | e[9];
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic cycle_check(input word_t e, input logic ebusy);
        @(posedge clk);
        #1;
        if (e.done) exp_sent++;
        check("tx_data", o_tx_data, e.d);
        check("tx_ctrl", 64'(o_tx_ctrl), 64'(e.c));
        check("busy", 64'(o_busy), 64'(ebusy));
        check("frame_done", 64'(o_frame_done), 64'(e.done));
        check("frames_sent", 64'(o_frames_sent), 64'(16'(exp_sent)));
    endtask

    task automatic idle_check(input int n);
        word_t e;
        e = '{d: IDLE_W, c: 8'hFF, done: 1'b0};
        for (int i = 0; i < n; i++) cycle_check(e, 1'b0);
    endtask

    // One enable session; with cnt=0 enable drops just after the last frame's START.
    task automatic run_session(input string name, input int len, input int ipg,
                               input int pat, input int cnt, input int nfr);
        int last_start;
        step = name;
        build(len, ipg, pat, nfr);
        last_start    = fstart_q[nfr-1];
        i_payload_len = 11'(len);
        i_ipg_len     = 8'(ipg);
        i_pattern_sel = 2'(pat);
        i_frame_count = 16'(cnt);
        i_enable      = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            cycle_check(exp_q[i], 1'b1);
            if (i == last_start) begin
                i_payload_len = 11'($urandom);
                i_ipg_len     = 8'($urandom);
                i_pattern_sel = 2'($urandom);
                i_frame_count = 16'($urandom_range(1, 3));
            end
            if (cnt == 0 && i == last_start + 1) i_enable = 1'b0;
        end
        idle_check(4);
        i_enable = 1'b0;
        idle_check(1);
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_enable      = 1'b0;
        i_payload_len = '0;
        i_ipg_len     = '0;
        i_pattern_sel = '0;
        i_frame_count = '0;

        step = "reset";
        idle_check(3);
        @(negedge clk);
        i_rst_n = 1'b1;
        idle_check(2);

        run_session("incr46", 46, 12, 0, 1, 1);
        run_session("incr64", 64, 12, 0, 2, 2);
        run_session("lfsr1500", 1500, 12, 1, 0, 10);
        run_session("clamp3", 3, 12, 0, 1, 1);
        run_session("const40", 40, 12, 2, 1, 1);
        run_session("ipg0", 46, 0, 0, 3, 3);
        run_session("ipg5", 46, 5, 3, 2, 2);
        run_session("len0", 0, 0, 1, 2, 2);

        for (int r = 0; r < 6; r++) begin
            int cnt;
            cnt = $urandom_range(0, 3);
            run_session("random", $urandom_range(0, 260), $urandom_range(0, 40),
                        $urandom_range(0, 3), cnt, (cnt == 0) ? 2 : cnt);
        end

        step = "rst_mid";
        build(200, 12, 0, 1);
        i_payload_len = 11'd200;
        i_ipg_len     = 8'd12;
        i_pattern_sel = 2'd0;
        i_frame_count = 16'd0;
        i_enable      = 1'b1;
        for (int i = 0; i < 3; i++) cycle_check(exp_q[i], 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        exp_sent = 0;
        check("rst_data", o_tx_data, IDLE_W);
        check("rst_ctrl", 64'(o_tx_ctrl), 64'(8'hFF));
        check("rst_busy", 64'(o_busy), 64'(1'b0));
        check("rst_done", 64'(o_frame_done), 64'(1'b0));
        check("rst_sent", 64'(o_frames_sent), 64'(16'd0));
        i_enable = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        idle_check(2);

        run_session("post_rst", 20, 3, 1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
